// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the memory request arbiter.
// Default channel count and outstanding depth used when the top is left unparameterised.
package mem_req_arbiter_pkg;

    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_MAX_OUTST = 4;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } arb_state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Upstream channel bundle plus the downstream SRAM-like port of the arbiter.
// slave = the arbiter, master = the surrounding core/bridge side.
interface mem_req_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int AW     = 32,
    parameter int DW     = 32
);
    logic [NUM_CH-1:0]                ch_req;
    logic [NUM_CH-1:0]                ch_wr;
    logic [NUM_CH-1:0][1:0]           ch_size;
    logic [NUM_CH-1:0][AW-1:0]        ch_addr;
    logic [NUM_CH-1:0][DW/8-1:0]      ch_wstrb;
    logic [NUM_CH-1:0][DW-1:0]        ch_wdata;
    logic [NUM_CH-1:0]                ch_addr_ok;
    logic [NUM_CH-1:0]                ch_data_ok;
    logic [DW-1:0]                    ch_rdata;

    logic                             mem_req;
    logic                             mem_wr;
    logic [1:0]                       mem_size;
    logic [AW-1:0]                    mem_addr;
    logic [DW/8-1:0]                  mem_wstrb;
    logic [DW-1:0]                    mem_wdata;
    logic                             mem_addr_ok;
    logic                             mem_data_ok;
    logic [DW-1:0]                    mem_rdata;

    modport slave (
        input  ch_req, ch_wr, ch_size, ch_addr, ch_wstrb, ch_wdata,
        output ch_addr_ok, ch_data_ok, ch_rdata,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output ch_req, ch_wr, ch_size, ch_addr, ch_wstrb, ch_wdata,
        input  ch_addr_ok, ch_data_ok, ch_rdata,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );

endinterface

// File: rtl/arb_id_fifo.sv
// Small FIFO holding the channel index of each accepted-but-unanswered request.
// Storage is not reset; clearing the pointers and count discards the contents.
module arb_id_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 1,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mem_req_arbiter.sv
// N-channel merger of SRAM-like ports onto one downstream port with in-order response routing.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise lowest channel index wins.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_OUTST = DEF_MAX_OUTST
) (
    input  logic              clk,
    input  logic              reset,
    mem_req_arbiter_if.slave  bus,
    output logic              resp_err
);

    localparam int IW = id_width(NUM_CH);
    localparam int CW = $clog2(MAX_OUTST + 1);

    arb_state_t        state, state_nxt;
    logic [NUM_CH-1:0] grant;
    logic [IW-1:0]     grant_idx, win_idx, head;
    logic              win_found, take, accept, push, pop;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     outst_cnt;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr;

    // Search upward from rr_ptr, wrapping; first requester wins.
    always_comb begin
        int c;
        c         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = (int'(rr_ptr) + i) % NUM_CH;
            if (!win_found && bus.ch_req[c]) begin
                win_found = 1'b1;
                win_idx   = IW'(c);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= (grant_idx == IW'(NUM_CH - 1)) ? '0 : grant_idx + IW'(1);
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!win_found && bus.ch_req[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
    end
`endif

    // Outstanding limit is checked at grant time, so S_REQ never meets a full FIFO.
    assign take   = (state == S_IDLE) && win_found && (outst_cnt < CW'(MAX_OUTST));
    assign accept = (state == S_REQ) && bus.mem_addr_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.mem_req    = 1'b0;
        bus.ch_addr_ok = '0;
        case (state)
            S_IDLE: begin
                if (take) state_nxt = S_REQ;
            end
            S_REQ: begin
                bus.mem_req = 1'b1;
                if (bus.mem_addr_ok) begin
                    bus.ch_addr_ok = grant;
                    state_nxt      = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant     <= '0;
            grant_idx <= '0;
        end else if (take) begin
            grant     <= NUM_CH'(1) << win_idx;
            grant_idx <= win_idx;
        end else if (accept) begin
            grant     <= '0;
        end
    end

    assign bus.mem_wr    = bus.ch_wr[grant_idx];
    assign bus.mem_size  = bus.ch_size[grant_idx];
    assign bus.mem_addr  = bus.ch_addr[grant_idx];
    assign bus.mem_wstrb = bus.ch_wstrb[grant_idx];
    assign bus.mem_wdata = bus.ch_wdata[grant_idx];

    assign push = accept && !fifo_full;
    assign pop  = bus.mem_data_ok && !fifo_empty;

    arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (IW)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (grant_idx),
        .pop   (pop),
        .head  (head),
        .count (outst_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.ch_data_ok = pop ? (NUM_CH'(1) << head) : '0;
    assign bus.ch_rdata   = bus.mem_rdata;

    // A response with nothing outstanding is dropped and flagged until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               resp_err <= 1'b0;
        else if (bus.mem_data_ok && fifo_empty)  resp_err <= 1'b1;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Parametrised N-channel merger of SRAM-like request/response ports onto a single downstream SRAM-like port. Generalises the fixed inst/data SRAM pair to NUM_CH channels.
- Adds multiple outstanding requests, in-order response routing and arbitration between channels.
- Sits between the CPU core ports (inst, data, future cache refill) and the memory/bus bridge.

Parameters:
- NUM_CH, 2, number of upstream channels (>=2).
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- MAX_OUTST, 4, maximum outstanding accepted-but-unanswered requests (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ch_req  in  NUM_CH  per-channel request valid
- ch_wr  in  NUM_CH  1=write
- ch_size  in  2*NUM_CH  per-channel size: 0=byte, 1=half, 2=word
- ch_addr  in  AW*NUM_CH  per-channel address
- ch_wstrb  in  (DW/8)*NUM_CH  per-channel byte strobes
- ch_wdata  in  DW*NUM_CH  per-channel write data
- ch_addr_ok  out  NUM_CH  request accepted, one-hot or zero
- ch_data_ok  out  NUM_CH  response returned, one-hot or zero
- ch_rdata  out  DW  read data, broadcast to all channels
- mem_req  out  1  downstream request valid
- mem_wr / mem_size / mem_addr / mem_wstrb / mem_wdata  out  1/2/AW/DW/8/DW  downstream request fields
- mem_addr_ok  in  1  downstream accept
- mem_data_ok  in  1  downstream response
- mem_rdata  in  DW  downstream read data
- resp_err  out  1  sticky flag: mem_data_ok received with no outstanding ID

Behaviour:
- Reset (async) values:
  - state=S_IDLE, grant=0, rr_ptr=0, FIFO empty, resp_err=0.
  - All ch_addr_ok, ch_data_ok and mem_req are 0.
- Channel contract: once ch_req is high, the channel holds all its request fields stable until it sees ch_addr_ok.
- FSM S_IDLE:
  - If any ch_req and outst_cnt<MAX_OUTST, register the winner into grant (one-hot) and go to S_REQ.
  - Otherwise stay; mem_req=0.
- FSM S_REQ:
  - mem_req=1; mem_* fields are muxed combinationally from the granted channel.
  - On mem_addr_ok:
    - ch_addr_ok[grant]=1 in the same cycle.
    - Push the channel index into the ID FIFO.
    - Update rr_ptr to grant index+1 mod NUM_CH.
    - Return to S_IDLE.
  - Otherwise hold.
- Throughput: at most 1 request per 2 cycles. Arbitration latency is 1 cycle from ch_req to mem_req.
- Response path: on mem_data_ok with FIFO non-empty:
  - ch_data_ok[head]=1 and ch_rdata=mem_rdata, same cycle (combinational).
  - Pop the head.
  - Responses are strictly in order.
- mem_data_ok with FIFO empty: drop the response and set resp_err=1; it stays set until reset.
- FIFO full (outst_cnt==MAX_OUTST): no new grant. A grant already in S_REQ cannot exist at full, because the count is checked at grant time.
- Simultaneous push+pop: both take effect and outst_cnt is unchanged. Push at full is impossible by construction. Pop-at-empty is handled by the resp_err rule.
- Pointer wrap: rd_ptr/wr_ptr wrap modulo MAX_OUTST. outst_cnt width is $clog2(MAX_OUTST+1).
- Reset mid-operation:
  - FIFO contents are discarded and the FSM returns to S_IDLE.
  - Late downstream responses after reset raise resp_err.
  - Upstream channels must be reset together with this block.
- ch_addr_ok/ch_data_ok never assert for a channel whose ch_req was not granted.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin. Search starts at rr_ptr, and the first requesting channel upward (wrapping) wins.
- Undefined: fixed priority, lowest index wins. rr_ptr logic is removed, and channel 0 can starve the others.

Decomposition:
- Shared header mycpu.v gains:
  - `MEM_SIZE_BYTE/HALF/WORD constants.
  - `ARB_S_IDLE/`ARB_S_REQ state encodings.
  - Default macros for NUM_CH/MAX_OUTST.
- One sub-module, arb_id_fifo: parametrised depth/width FIFO with push, pop, head, count, full and empty. Depth is MAX_OUTST; width is $clog2(NUM_CH), min 1.

Test Plan:
- Single read: ch_req[1]=1, addr 0x1C000000, mem_addr_ok next cycle, mem_data_ok 3 cycles later with 0xDEADBEEF -> mem_addr=0x1C000000, ch_addr_ok=2'b10, then ch_data_ok=2'b10 with ch_rdata=0xDEADBEEF; resp_err=0.
- Contention, ARB_ROUND_ROBIN_EN defined, NUM_CH=2, both channels requesting continuously with mem_addr_ok always 1 -> grants alternate 0,1,0,1. Undefined -> grants are always 0.
- Outstanding limit, MAX_OUTST=4: mem_data_ok held low, 6 requests offered -> exactly 4 ch_addr_ok pulses and mem_req stays 0 afterwards. After one mem_data_ok -> exactly one more grant.
- In-order routing: accept ch0, ch1, ch0, then return 3 responses with rdata 0xA, 0xB, 0xC -> ch_data_ok sequence 01,10,01 with matching data.
- Error and reset: mem_data_ok with empty FIFO -> resp_err=1 and no ch_data_ok. Assert reset with 2 outstanding -> all outputs 0 immediately; a subsequent mem_data_ok sets resp_err again.
